mac_pipe: RTL and testbench

Parametrised, pipelined unsigned multiply-add unit with an accumulate mode. It computes A*B+C per input beat, or sums ACC_LEN products into one result. Each result is fitted to the output width by truncation or saturation, with an overflow flag. It sits in the datapath wherever registered product/sum arithmetic is needed, with a valid strobe on input and output.

---
 rtl/mac_pipe_pkg.sv | 14 +
 rtl/mac_pipe_fit.sv | 34 +++
 rtl/mac_pipe.sv | 155 +++++++++++++++
 tb/tb_mac_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pipe_pkg.sv
// Shared types and sizing helpers for the mac_pipe multiply-add unit.
package mac_pipe_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Product width plus growth for ACC_LEN products and one extra addend.
  function automatic int calc_full_w(input int width, input int acc_len);
    return (32'sd2 * width) + $clog2(acc_len) + 32'sd1;
  endfunction

endpackage

// File: rtl/mac_pipe_fit.sv
// Fits a full-precision unsigned value into OUT_WIDTH bits by truncation or
// saturation, flagging any value above the output range.
module mac_pipe_fit #(
  parameter int FULL_W    = 20,
  parameter int OUT_WIDTH = 8,
  parameter bit SAT       = 1'b0
) (
  input  logic [FULL_W-1:0]    i_x,
  output logic [OUT_WIDTH-1:0] o_y,
  output logic                 o_ovf
);

  generate
    if (FULL_W > OUT_WIDTH) begin : g_narrow
      logic w_over;

      assign w_over = |i_x[FULL_W-1:OUT_WIDTH];

      // Pick clipped or wrapped value when the upper bits are in use.
      always_comb begin
        o_ovf = w_over;
        if (w_over && SAT) begin
          o_y = '1;
        end else begin
          o_y = i_x[OUT_WIDTH-1:0];
        end
      end
    end else begin : g_wide
      assign o_ovf = 1'b0;
      assign o_y   = OUT_WIDTH'(i_x);
    end
  endgenerate

endmodule

// File: rtl/mac_pipe.sv
// Two-stage unsigned A*B+C pipeline with an ACC_LEN-product accumulate mode
// and a fitted, registered result.
module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int ACC_LEN   = 4,
  parameter bit SAT       = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  output logic [OUT_WIDTH-1:0] DATA_OUT,
  output logic                 out_valid,
  output logic                 ovf,
  output logic                 frame_drop
);

  localparam int FULL_W = calc_full_w(WIDTH, ACC_LEN);
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = $clog2(ACC_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN);

  logic [PROD_W-1:0]    r_prod;
  logic [WIDTH-1:0]     r_c;
  logic                 r_mode;
  logic                 r_v1;

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [FULL_W-1:0]    r_acc;

  logic [PROD_W-1:0]    w_a_ext;
  logic [PROD_W-1:0]    w_b_ext;
  logic [FULL_W-1:0]    w_prod_full;
  logic [FULL_W-1:0]    w_c_full;
  logic [FULL_W-1:0]    w_sum;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [CNT_W-1:0]     w_cnt_step;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [FULL_W-1:0]    w_acc_nxt;
  logic                 w_fire;
  logic                 w_drop;
  logic [OUT_WIDTH-1:0] w_fit_y;
  logic                 w_fit_ovf;

  assign w_a_ext     = {{WIDTH{1'b0}}, A};
  assign w_b_ext     = {{WIDTH{1'b0}}, B};
  assign w_prod_full = FULL_W'(r_prod);
  assign w_c_full    = FULL_W'(r_c);
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  // Stage 1: capture the product and the addend for each qualified beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod <= '0;
      r_c    <= '0;
      r_mode <= 1'b0;
      r_v1   <= 1'b0;
    end else if (in_valid) begin
      r_prod <= w_a_ext * w_b_ext;
      r_c    <= C;
      r_mode <= mode;
      r_v1   <= 1'b1;
    end else begin
      r_v1   <= 1'b0;
    end
  end

  // C only enters on a frame's first beat; later beats add to the running sum.
  always_comb begin
    if (r_mode && (r_state == ACCUM)) begin
      w_sum = r_acc + w_prod_full;
    end else begin
      w_sum = w_prod_full + w_c_full;
    end
  end

  mac_pipe_fit #(
    .FULL_W    (FULL_W),
    .OUT_WIDTH (OUT_WIDTH),
    .SAT       (SAT)
  ) u_fit (
    .i_x   (w_sum),
    .o_y   (w_fit_y),
    .o_ovf (w_fit_ovf)
  );

  // Frame state machine: next state, counter, accumulator and result strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_cnt_step  = CNT_ONE;
    w_fire      = 1'b0;
    w_drop      = 1'b0;
    if (r_v1) begin
      if (!r_mode) begin
        w_fire      = 1'b1;
        w_drop      = (r_state == ACCUM);
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          IDLE:    w_cnt_step = CNT_ONE;
          ACCUM:   w_cnt_step = w_cnt_inc;
          default: w_cnt_step = CNT_ONE;
        endcase
        if (w_cnt_step == CNT_LAST) begin
          w_fire      = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end else begin
          w_state_nxt = ACCUM;
          w_cnt_nxt   = w_cnt_step;
          w_acc_nxt   = w_sum;
        end
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Stage 2: frame state and registered outputs; DATA_OUT holds between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      DATA_OUT   <= '0;
      out_valid  <= 1'b0;
      ovf        <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      out_valid  <= w_fire;
      ovf        <= w_fire & w_fit_ovf;
      frame_drop <= w_drop;
      if (w_fire) begin
        DATA_OUT <= w_fit_y;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: a transaction-level model of the
// multiply-add / accumulate rules checks both a truncating and a saturating DUT.
module tb_mac_pipe;

  localparam int ACC_LEN = 4;
  localparam int NCYC    = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       mode;
  logic [7:0] A, B, C;

  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d1_valid, d0_ovf, d1_ovf, d0_drop, d1_drop;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-cycle record of what was driven
  logic       bv [0:NCYC-1];
  logic       bm [0:NCYC-1];
  logic       br [0:NCYC-1];
  logic [7:0] ba [0:NCYC-1];
  logic [7:0] bb [0:NCYC-1];
  logic [7:0] bc [0:NCYC-1];

  // Model state
  logic   m_act;
  int     m_cnt;
  longint m_acc;
  longint m_d0, m_d1;

  mac_pipe #(.WIDTH(8), .OUT_WIDTH(8), .ACC_LEN(ACC_LEN), .SAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
    .A(A), .B(B), .C(C),
    .DATA_OUT(d0_data), .out_valid(d0_valid), .ovf(d0_ovf), .frame_drop(d0_drop)
  );

  mac_pipe #(.WIDTH(8), .OUT_WIDTH(8), .ACC_LEN(ACC_LEN), .SAT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
    .A(A), .B(B), .C(C),
    .DATA_OUT(d1_data), .out_valid(d1_valid), .ovf(d1_ovf), .frame_drop(d1_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic r);
    @(posedge clk);
    #1;
    in_valid = v; mode = m; A = a; B = b; C = c; reset = r;
    if (cyc < NCYC) begin
      bv[cyc] = v; bm[cyc] = m; ba[cyc] = a; bb[cyc] = b; bc[cyc] = c; br[cyc] = r;
    end else begin
      n_chk++;
      n_err++;
      $display("FAIL cycle_budget at cycle %0d: got %0d expected below %0d", cyc, cyc, NCYC);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  // Reference model, evaluated per output cycle from the recorded beats
  always @(negedge clk) begin : model_cmp
    longint p, res;
    logic   e_v, e_drop, e_ovf;
    if (cyc >= 2 && cyc < NCYC) begin
      e_v = 1'b0; e_drop = 1'b0; e_ovf = 1'b0;
      if (br[cyc-1]) begin
        m_act = 1'b0; m_cnt = 0; m_acc = 0; m_d0 = 0; m_d1 = 0;
      end else if (bv[cyc-2] && !br[cyc-2]) begin
        p = longint'(ba[cyc-2]) * longint'(bb[cyc-2]);
        res = 0;
        if (!bm[cyc-2]) begin
          e_drop = m_act;
          m_act = 1'b0; m_cnt = 0;
          res = p + longint'(bc[cyc-2]);
          e_v = 1'b1;
        end else begin
          if (!m_act) begin
            m_acc = p + longint'(bc[cyc-2]); m_cnt = 1; m_act = 1'b1;
          end else begin
            m_acc = m_acc + p; m_cnt = m_cnt + 1;
          end
          if (m_cnt == ACC_LEN) begin
            res = m_acc; e_v = 1'b1; m_act = 1'b0; m_cnt = 0;
          end
        end
        if (e_v) begin
          e_ovf = (res > 255);
          m_d0  = res % 256;
          m_d1  = (res > 255) ? 255 : res;
        end
      end
      chk("valid_trunc", 64'(d0_valid), 64'(e_v));
      chk("valid_sat",   64'(d1_valid), 64'(e_v));
      chk("drop_trunc",  64'(d0_drop),  64'(e_drop));
      chk("drop_sat",    64'(d1_drop),  64'(e_drop));
      chk("ovf_trunc",   64'(d0_ovf),   64'(e_ovf));
      chk("ovf_sat",     64'(d1_ovf),   64'(e_ovf));
      chk("data_trunc",  64'(d0_data),  64'(m_d0));
      chk("data_sat",    64'(d1_data),  64'(m_d1));
    end
  end

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      bv[i] = 1'b0; bm[i] = 1'b0; br[i] = 1'b0; ba[i] = 8'd0; bb[i] = 8'd0; bc[i] = 8'd0;
    end
    m_act = 1'b0; m_cnt = 0; m_acc = 0; m_d0 = 0; m_d1 = 0;
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; A = 8'd0; B = 8'd0; C = 8'd0;
    br[0] = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("reset_data", 64'(d0_data), 64'd0);
    chk("reset_valid", 64'(d0_valid), 64'd0);

    // Single beat 3*5+7
    drive(1'b1, 1'b0, 8'd3, 8'd5, 8'd7, 1'b0);
    idle(2);
    @(negedge clk);
    chk("single_valid", 64'(d0_valid), 64'd1);
    chk("single_data", 64'(d0_data), 64'd22);
    chk("single_ovf", 64'(d0_ovf), 64'd0);

    // 200*2+100 = 500 overflows 8 bits
    drive(1'b1, 1'b0, 8'd200, 8'd2, 8'd100, 1'b0);
    idle(2);
    @(negedge clk);
    chk("ovf_trunc_data", 64'(d0_data), 64'd244);
    chk("ovf_trunc_flag", 64'(d0_ovf), 64'd1);
    chk("ovf_sat_data", 64'(d1_data), 64'd255);
    chk("ovf_sat_flag", 64'(d1_ovf), 64'd1);

    // Accumulate frame with random gaps: 12+12+30+56 = 110
    drive(1'b1, 1'b1, 8'd1, 8'd2, 8'd10, 1'b0);
    idle($urandom_range(0, 3));
    drive(1'b1, 1'b1, 8'd3, 8'd4, 8'd99, 1'b0);
    idle($urandom_range(0, 3));
    drive(1'b1, 1'b1, 8'd5, 8'd6, 8'd99, 1'b0);
    idle($urandom_range(0, 3));
    drive(1'b1, 1'b1, 8'd7, 8'd8, 8'd99, 1'b0);
    idle(2);
    @(negedge clk);
    chk("acc_valid", 64'(d0_valid), 64'd1);
    chk("acc_data", 64'(d0_data), 64'd110);

    // Partial frame interrupted by a single beat
    drive(1'b1, 1'b1, 8'd1, 8'd1, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 8'd1, 8'd1, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd2, 8'd2, 8'd1, 1'b0);
    idle(2);
    @(negedge clk);
    chk("drop_pulse", 64'(d0_drop), 64'd1);
    chk("drop_valid", 64'(d0_valid), 64'd1);
    chk("drop_data", 64'(d0_data), 64'd5);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'd1, 8'd1, 8'd0, 1'b0);
    idle(2);
    @(negedge clk);
    chk("after_drop_data", 64'(d0_data), 64'd4);

    // Reset mid-frame, then a clean frame of 2*2
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'd2, 8'd2, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("midreset_data", 64'(d0_data), 64'd0);
    chk("midreset_drop", 64'(d0_drop), 64'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'd2, 8'd2, 8'd0, 1'b0);
    idle(2);
    @(negedge clk);
    chk("postreset_data", 64'(d0_data), 64'd16);
    chk("postreset_valid", 64'(d0_valid), 64'd1);

    // Back-to-back single beats
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, 1'b0, 8'(i), 8'd1, 8'd0, 1'b0);
      else idle(1);
      @(negedge clk);
      if (i >= 2) begin
        chk("stream_valid", 64'(d0_valid), 64'd1);
        chk("stream_data", 64'(d0_data), 64'(i - 2));
      end
    end

    // Randomized traffic including boundary operands and occasional reset
    for (int i = 0; i < 500; i++) begin
      int sel;
      logic [7:0] ra, rb, rc;
      sel = $urandom_range(0, 99);
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      if (sel < 10) begin
        ra = 8'd255; rb = 8'd255; rc = 8'd255;
      end else if (sel < 15) begin
        ra = 8'd0;
      end
      if (sel == 99) drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      else drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, ra, rb, rc, 1'b0);
    end
    idle(4);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
